// File: rtl/types_pkg.sv
// Shared types and register offsets for the memory-mapped UART transmitter.
package types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam logic [1:0] UART_TXDATA_OFS = 2'd0;
  localparam logic [1:0] UART_STATUS_OFS = 2'd1;
  localparam int         UART_OVF_BIT    = 3;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory port as seen by a memory-mapped peripheral.
interface mmio_uart_tx_if;
  import types_pkg::*;

  word_t Addr;
  word_t WriteData;
  logic  MemWrite;
  logic  Sel;
  word_t RdData;

  modport master (output Addr, WriteData, MemWrite, input Sel, RdData);
  modport slave  (input Addr, WriteData, MemWrite, output Sel, RdData);

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data (head of queue always visible).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rdata   = mem[rd_ptr_reg];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage carries no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA pushes into a FIFO, STATUS is read combinationally.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module mmio_uart_tx
  import types_pkg::*;
#(
  parameter word_t BASE_ADDR    = 32'hFFFF_0000,
  parameter int    CLKS_PER_BIT = 434,
  parameter int    FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx
);
  localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam int               CW       = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_STOP   = STOP;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = PARITY;
`endif

  logic             sel;
  logic             push_req;
  logic             ovf_set;
  logic             ovf_clr;
  logic             ovf_reg;
  logic             ovf_next;
  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             tx_reg;
  logic             busy;
  logic             launch;
  word_t            status_word;
  logic             unused_bits;
`ifdef UART_TX_PARITY_EN
  logic             par_reg;
`endif

  // Address decode and bus-side register effects
  assign sel      = (bus.Addr[31:4] == BASE_ADDR[31:4]);
  assign push_req = sel & bus.MemWrite & (bus.Addr[3:2] == UART_TXDATA_OFS);
  assign ovf_clr  = sel & bus.MemWrite & (bus.Addr[3:2] == UART_STATUS_OFS)
                  & bus.WriteData[UART_OVF_BIT];
  // Fullness is the pre-edge value, so a simultaneous pop never rescues a push.
  assign ovf_set   = push_req & fifo_full;
  assign fifo_push = push_req & ~fifo_full;
  assign ovf_next  = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_reg);

  assign unused_bits = ^{bus.Addr[1:0], bus.WriteData[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srst  (reset),
    .push  (fifo_push),
    .wdata (bus.WriteData[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A new frame starts from IDLE or straight out of a finishing STOP.
  assign launch   = ~fifo_empty & ((state_reg == S_IDLE) |
                                   ((state_reg == S_STOP) & (cnt_reg == '0)));
  assign fifo_pop = launch;
  assign busy     = (state_reg != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      ovf_reg     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg     <= 1'b0;
`endif
    end else begin
      ovf_reg <= ovf_next;
      if (launch) begin
        state_reg   <= S_START;
        cnt_reg     <= CNT_LOAD;
        bit_idx_reg <= '0;
        shift_reg   <= fifo_rdata;
        tx_reg      <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_reg     <= even_parity(fifo_rdata);
`endif
      end else begin
        case (state_reg)
          S_IDLE: begin
            tx_reg <= 1'b1;
          end
          S_START: begin
            if (cnt_reg == '0) begin
              state_reg <= S_DATA;
              cnt_reg   <= CNT_LOAD;
              tx_reg    <= shift_reg[0];
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          S_DATA: begin
            if (cnt_reg == '0) begin
              cnt_reg <= CNT_LOAD;
              if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_reg <= S_PARITY;
                tx_reg    <= par_reg;
`else
                state_reg <= S_STOP;
                tx_reg    <= 1'b1;
`endif
              end else begin
                // LSB-first: the next bit is always at position 1 before the shift.
                bit_idx_reg <= bit_idx_reg + 3'd1;
                tx_reg      <= shift_reg[1];
                shift_reg   <= {1'b0, shift_reg[7:1]};
              end
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (cnt_reg == '0) begin
              state_reg <= S_STOP;
              cnt_reg   <= CNT_LOAD;
              tx_reg    <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
`endif
          S_STOP: begin
            if (cnt_reg == '0) begin
              state_reg <= S_IDLE;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          default: begin
            state_reg <= S_IDLE;
            tx_reg    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx          = tx_reg;
  assign status_word = {20'd0, 4'(fifo_count), 4'd0, ovf_reg, busy, fifo_empty, fifo_full};
  assign bus.Sel     = sel;
  assign bus.RdData  = (sel && (bus.Addr[3:2] == UART_STATUS_OFS)) ? status_word : '0;

endmodule
